lpf_lock_ctrl: RTL and testbench
================================

# lpf_lock_ctrl

Digital sequencer for the PLL's 2nd-order passive loop filter and charge pump. It precharges the filter after start, runs a fast-lock phase with boosted charge-pump current and reduced filter resistance, then gears down to nominal loop bandwidth. It monitors bang-bang phase-detector decisions to declare lock, and to fall back to fast-lock on loss of lock. It sits between the PFD/lock-detect logic and the charge-pump/LPF configuration inputs, clocked by the reference clock.

## Interface
- `PRECHG_CYC`, 64: cycles the filter precharge switch is held on.
- `LOCK_CNT`, 16: consecutive PD sign alternations that declare coarse lock.
- `SETTLE_CYC`, 32: minimum cycles spent in SETTLE.
- `UNLOCK_RUN`, 8: consecutive same-sign PD decisions in LOCKED that declare loss of lock.
- `ICP_FAST`, 12: charge-pump current code during FAST.
- `ICP_NORM`, 3: charge-pump current code after settling; must satisfy ICP_NORM ≤ ICP_FAST ≤ 15.
- `GEAR_STEP_CYC`, 8: cycles per one-code current step (gear-shift build only).
- `CNT_W`, 8: width of all internal counters; every count parameter must be < 2^CNT_W.

Ports:
- `clk`, in, 1: reference clock.
- `rst`, in, 1: reset. Synchronous, active-high.
- `start`, in, 1: single-cycle or level request to begin acquisition. Sampled only in IDLE.
- `pd_valid`, in, 1: one PD decision is present this cycle.
- `pd_up`, in, 1: PD decision sign; 1 = feedback clock late.
- `prechg_en`, out, 1: closes the LPF precharge switch (drives vc toward vinit).
- `icp_code`, out, 4: charge-pump current code.
- `r_sel`, out, 1: 1 = reduced filter R (fast mode), 0 = nominal R.
- `locked`, out, 1: loop declared locked.
- `state`, out, 3: current FSM state, for debug.

## Operation
- States and encodings: IDLE=0, PRECHG=1, FAST=2, SETTLE=3, LOCKED=4.
- Outputs are a registered Moore decode of `state`:
  - IDLE and PRECHG: icp_code=0, r_sel=0.
  - prechg_en=1 only in PRECHG.
  - FAST: icp_code=ICP_FAST, r_sel=1.
  - SETTLE: r_sel=0; icp_code as described under Configuration.
  - LOCKED: icp_code=ICP_NORM, r_sel=0, locked=1.
- IDLE→PRECHG when `start`=1. `start` is ignored in all other states.
- PRECHG→FAST after exactly PRECHG_CYC cycles in PRECHG.
- Lock detector:
  - `last_sign` is invalidated on every entry to FAST and on every entry to LOCKED.
  - The first valid decision after invalidation only loads `last_sign`; it does not count.
  - In FAST, a valid decision with pd_up≠last_sign increments alt_cnt. A same-sign decision clears alt_cnt to 0.
  - FAST→SETTLE on the cycle alt_cnt reaches LOCK_CNT.
- SETTLE→LOCKED when the settle counter ≥ SETTLE_CYC and icp_code==ICP_NORM. PD decisions are ignored in SETTLE.
- In LOCKED, run_cnt counts consecutive same-sign valid decisions; an alternation resets it to 1. run_cnt saturates at UNLOCK_RUN.
- LOCKED→FAST (relock, no precharge) when run_cnt reaches UNLOCK_RUN.
- Cycles with pd_valid=0 leave alt_cnt, run_cnt and last_sign unchanged.
- All counters clear on every state entry.

## Timing
- Reset values: state=IDLE, prechg_en=0, icp_code=0, r_sel=0, locked=0; all counters 0; last_sign invalid.
- rst=1 in any state, including mid-PRECHG or mid-SETTLE, returns the block to IDLE on that clock edge. rst takes priority over start.
- Latency: start sampled at edge N → state=PRECHG and prechg_en=1 after edge N. prechg_en stays high for exactly PRECHG_CYC cycles.
- The decisive pd_valid sampled at edge N changes state and outputs after edge N. There is no combinational input→output path.
- pd_valid may be asserted on consecutive cycles; one decision is taken per cycle.

## Configuration
- `LPF_CTRL_GEARSHIFT_EN` defined:
  - On SETTLE entry, icp_code starts at ICP_FAST.
  - icp_code decrements by 1 every GEAR_STEP_CYC cycles until it equals ICP_NORM.
  - SETTLE therefore lasts max(SETTLE_CYC, (ICP_FAST−ICP_NORM)·GEAR_STEP_CYC) cycles.
- `LPF_CTRL_GEARSHIFT_EN` undefined:
  - icp_code=ICP_NORM for the whole of SETTLE.
  - SETTLE lasts exactly SETTLE_CYC cycles.
  - GEAR_STEP_CYC is unused.

## Structure
- Package `lpf_ctrl_pkg` holds:
  - the state enum typedef (3-bit);
  - `ICP_W`=4;
  - the icp code type.
- One sub-module, `lpf_lock_det`, holds last_sign, alt_cnt and run_cnt. It has `mode` (count alternations / count runs) and `clr` inputs, and outputs `lock_hit` and `unlock_hit`.
- The top level holds the FSM, the cycle counter and the gear-shift logic.

## Test plan
- Reset mid-operation: rst asserted at cycle 10 of PRECHG → state=0, prechg_en=0, icp_code=0 on the next cycle. A start 3 cycles later restarts a full 64-cycle precharge.
- Nominal acquisition: start, then 16 alternating PD decisions after the first loading decision → FAST lasts until the 16th alternation; r_sel drops and locked rises SETTLE_CYC=32 cycles later.
- Alternation break: in FAST, 10 alternations, one repeated sign, then 16 alternations → SETTLE is entered only after the final 16.
- Loss of lock: in LOCKED, 8 consecutive pd_up=1 decisions (gaps with pd_valid=0 allowed) → state=FAST, icp_code=12, r_sel=1, locked=0. Seven same-sign decisions followed by a flip → remain LOCKED.
- Gear shift (macro defined): on SETTLE entry icp_code steps 12,11,…,3, one step per 8 cycles; locked asserts after 72 cycles. Macro undefined: icp_code=3 immediately and locked asserts after 32 cycles.
- start pulse during FAST or LOCKED → no state change.

Source files
------------

// File: rtl/lpf_ctrl_pkg.sv
// Shared types for the PLL loop-filter / charge-pump lock sequencer.
package lpf_ctrl_pkg;

  localparam int ICP_W = 4;

  typedef logic [ICP_W-1:0] icp_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRECHG = 3'd1,
    ST_FAST   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_LOCKED = 3'd4
  } lpf_state_e;

  typedef enum logic {
    DET_ALT = 1'b0,
    DET_RUN = 1'b1
  } det_mode_e;

endpackage

// File: rtl/lpf_lock_det.sv
// Bang-bang PD lock detector: counts sign alternations (acquire) or
// same-sign runs (loss-of-lock watch) from consecutive valid decisions.
module lpf_lock_det
  import lpf_ctrl_pkg::*;
#(
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_RUN = 8,
  parameter int CNT_W      = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      clr,
  input  det_mode_e mode,
  input  logic      pd_valid,
  input  logic      pd_up,
  output logic      lock_hit,
  output logic      unlock_hit
);

  logic             sign_vld;
  logic             last_sign;
  logic [CNT_W-1:0] alt_cnt;
  logic [CNT_W-1:0] run_cnt;
  logic             alt;
  logic             same;

  always_comb begin
    alt        = pd_valid && sign_vld && (pd_up != last_sign);
    same       = pd_valid && sign_vld && (pd_up == last_sign);
    lock_hit   = (mode == DET_ALT) && alt  && (alt_cnt >= CNT_W'(LOCK_CNT - 1));
    unlock_hit = (mode == DET_RUN) && same && (run_cnt >= CNT_W'(UNLOCK_RUN - 1));
  end

  // The first decision after a clear only seeds last_sign.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sign_vld  <= 1'b0;
      last_sign <= 1'b0;
      alt_cnt   <= '0;
      run_cnt   <= '0;
    end else if (pd_valid) begin
      sign_vld  <= 1'b1;
      last_sign <= pd_up;
      if (sign_vld) begin
        if (mode == DET_ALT) begin
          alt_cnt <= alt ? alt_cnt + CNT_W'(1) : '0;
        end else if (same) begin
          if (run_cnt != CNT_W'(UNLOCK_RUN)) run_cnt <= run_cnt + CNT_W'(1);
        end else begin
          run_cnt <= CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/lpf_lock_ctrl.sv
// Loop-filter precharge / fast-lock / gear-down sequencer with PD lock detect.
// Optional icp gear-shift during SETTLE: define LPF_CTRL_GEARSHIFT_EN.
//   state  | meaning
//   IDLE   | waiting for start, CP off
//   PRECHG | precharge switch closed for PRECHG_CYC cycles
//   FAST   | boosted icp, reduced R, counting PD alternations
//   SETTLE | nominal R, icp gearing down, PD ignored
//   LOCKED | nominal loop, watching for same-sign runs
module lpf_lock_ctrl
  import lpf_ctrl_pkg::*;
#(
  parameter int PRECHG_CYC    = 64,
  parameter int LOCK_CNT      = 16,
  parameter int SETTLE_CYC    = 32,
  parameter int UNLOCK_RUN    = 8,
  parameter int ICP_FAST      = 12,
  parameter int ICP_NORM      = 3,
`ifdef LPF_CTRL_GEARSHIFT_EN
  parameter int GEAR_STEP_CYC = 8,
`endif
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pd_valid,
  input  logic             pd_up,
  output logic             prechg_en,
  output logic [ICP_W-1:0] icp_code,
  output logic             r_sel,
  output logic             locked,
  output logic [2:0]       state
);

  lpf_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             entry;
  logic             settle_done;
  logic             lock_hit, unlock_hit;
  logic             det_valid;
  det_mode_e        det_mode;
  logic             prechg_d, r_sel_d, locked_d;
  icp_t             icp_d;
  icp_t             icp_settle;

`ifdef LPF_CTRL_GEARSHIFT_EN
  localparam icp_t ICP_SETTLE_INIT = ICP_W'(ICP_FAST);
  logic [CNT_W-1:0] gear_cnt_q;
  logic             gear_tick;

  // icp_settle is the code SETTLE will show next cycle, so the exit test
  // fires on the cycle the final step lands.
  always_comb begin
    gear_tick  = (state_q == ST_SETTLE) && (gear_cnt_q == CNT_W'(GEAR_STEP_CYC - 1));
    icp_settle = (gear_tick && (icp_code > ICP_W'(ICP_NORM))) ? icp_code - ICP_W'(1) : icp_code;
  end

  always_ff @(posedge clk) begin
    if (rst || entry || gear_tick) gear_cnt_q <= '0;
    else if (state_q == ST_SETTLE) gear_cnt_q <= gear_cnt_q + CNT_W'(1);
  end
`else
  localparam icp_t ICP_SETTLE_INIT = ICP_W'(ICP_NORM);
  assign icp_settle = ICP_W'(ICP_NORM);
`endif

  assign det_valid   = pd_valid && ((state_q == ST_FAST) || (state_q == ST_LOCKED));
  assign det_mode    = (state_q == ST_LOCKED) ? DET_RUN : DET_ALT;
  assign settle_done = (cnt_q >= CNT_W'(SETTLE_CYC - 1)) && (icp_settle == ICP_W'(ICP_NORM));

  lpf_lock_det #(
    .LOCK_CNT  (LOCK_CNT),
    .UNLOCK_RUN(UNLOCK_RUN),
    .CNT_W     (CNT_W)
  ) u_lock_det (
    .clk       (clk),
    .rst       (rst),
    .clr       (entry),
    .mode      (det_mode),
    .pd_valid  (det_valid),
    .pd_up     (pd_up),
    .lock_hit  (lock_hit),
    .unlock_hit(unlock_hit)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_PRECHG;
      ST_PRECHG: if (cnt_q == CNT_W'(PRECHG_CYC - 1)) state_d = ST_FAST;
      ST_FAST:   if (lock_hit) state_d = ST_SETTLE;
      ST_SETTLE: if (settle_done) state_d = ST_LOCKED;
      ST_LOCKED: if (unlock_hit) state_d = ST_FAST;
      default:   state_d = ST_IDLE;
    endcase

    entry = (state_d != state_q);
    if (entry || !((state_q == ST_PRECHG) || (state_q == ST_SETTLE))) cnt_d = '0;
    else if (&cnt_q) cnt_d = cnt_q;
    else cnt_d = cnt_q + CNT_W'(1);

    // Outputs decode the next state so they register alongside it.
    prechg_d = 1'b0;
    icp_d    = '0;
    r_sel_d  = 1'b0;
    locked_d = 1'b0;
    unique case (state_d)
      ST_PRECHG: prechg_d = 1'b1;
      ST_FAST: begin
        icp_d   = ICP_W'(ICP_FAST);
        r_sel_d = 1'b1;
      end
      ST_SETTLE: icp_d = entry ? ICP_SETTLE_INIT : icp_settle;
      ST_LOCKED: begin
        icp_d    = ICP_W'(ICP_NORM);
        locked_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      prechg_en <= 1'b0;
      icp_code  <= '0;
      r_sel     <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prechg_en <= prechg_d;
      icp_code  <= icp_d;
      r_sel     <= r_sel_d;
      locked    <= locked_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_lpf_lock_ctrl.sv
// Directed scoreboard bench for lpf_lock_ctrl (default parameters).
module tb_lpf_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, pd_valid, pd_up;
  logic       prechg_en, r_sel, locked;
  logic [3:0] icp_code;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [9:0] v;
  } exp_t;
  exp_t sb[$];

  // packed observation: {state, prechg_en, icp_code, r_sel, locked}
  localparam logic [9:0] V_IDLE = {3'd0, 1'b0, 4'd0,  1'b0, 1'b0};
  localparam logic [9:0] V_PRE  = {3'd1, 1'b1, 4'd0,  1'b0, 1'b0};
  localparam logic [9:0] V_FAST = {3'd2, 1'b0, 4'd12, 1'b1, 1'b0};
  localparam logic [9:0] V_LOCK = {3'd4, 1'b0, 4'd3,  1'b0, 1'b1};

`ifdef LPF_CTRL_GEARSHIFT_EN
  localparam int SL = 72;
  function automatic logic [3:0] settle_icp(input int k);
    return 4'(12 - k / 8);
  endfunction
`else
  localparam int SL = 32;
  function automatic logic [3:0] settle_icp(input int k);
    return (k >= 0) ? 4'd3 : 4'd0;
  endfunction
`endif

  function automatic logic [9:0] v_settle(input int k);
    return {3'd3, 1'b0, settle_icp(k), 1'b0, 1'b0};
  endfunction

  lpf_lock_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pd_valid (pd_valid),
    .pd_up    (pd_up),
    .prechg_en(prechg_en),
    .icp_code (icp_code),
    .r_sel    (r_sel),
    .locked   (locked),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic compare();
    exp_t       x;
    logic [9:0] obs;
    obs = {state, prechg_en, icp_code, r_sel, locked};
    x   = sb.pop_front();
    checks++;
    assert (obs === x.v)
    else begin
      errors++;
      $error("FAIL %s: observed st/pe/icp/rs/lk=%b expected=%b", x.tag, obs, x.v);
    end
  endtask

  // Drive one cycle of inputs, record the expectation, clock, then check.
  task automatic drive(input logic r, input logic s, input logic v, input logic u,
                       input string tag, input logic [9:0] e);
    exp_t x;
    rst = r; start = s; pd_valid = v; pd_up = u;
    x.tag = tag; x.v = e;
    sb.push_back(x);
    @(posedge clk);
    #1;
    compare();
  endtask

  // From fresh FAST: one seeding decision then 16 alternations, with gaps.
  task automatic acquire(input string tag);
    logic sgn = 1'b0;
    drive(0, 1, 1, sgn, {tag, "_seed"}, V_FAST);
    for (int i = 1; i <= 16; i++) begin
      if (i % 5 == 0) drive(0, 0, 0, ~sgn, {tag, "_gap"}, V_FAST);
      sgn = ~sgn;
      drive(0, (i == 3), 1, sgn, {tag, "_alt"}, (i < 16) ? V_FAST : v_settle(0));
    end
  endtask

  task automatic settle_run(input int n, input string tag);
    for (int k = 1; k <= n; k++)
      drive(0, 1'(k == 2), 1, 1'($urandom_range(0, 1)), tag, (k < SL) ? v_settle(k) : V_LOCK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic sgn;

    // reset with start held: rst wins
    drive(1, 1, 0, 0, "reset_start", V_IDLE);
    drive(1, 1, 0, 0, "reset_start", V_IDLE);
    drive(0, 0, 1, 1, "idle_hold", V_IDLE);

    // reset in the middle of precharge
    drive(0, 1, 0, 0, "start", V_PRE);
    for (int i = 2; i <= 9; i++) drive(0, 0, 0, 0, "prechg_early", V_PRE);
    drive(1, 1, 0, 0, "rst_mid_prechg", V_IDLE);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, "idle_after_rst", V_IDLE);

    // full precharge: exactly 64 cycles, start ignored meanwhile
    drive(0, 1, 0, 0, "restart", V_PRE);
    for (int i = 2; i <= 64; i++) drive(0, 1'(i % 7 == 0), 1, 1'(i), "prechg_hold", V_PRE);
    drive(0, 0, 0, 0, "prechg_end", V_FAST);

    // alternation break: 10 alternations, a repeat, then 16 more
    sgn = 1'b0;
    drive(0, 0, 1, sgn, "brk_seed", V_FAST);
    for (int i = 0; i < 10; i++) begin
      sgn = ~sgn;
      drive(0, 0, 1, sgn, "brk_alt10", V_FAST);
    end
    drive(0, 1, 1, sgn, "brk_repeat", V_FAST);
    for (int i = 1; i <= 16; i++) begin
      sgn = ~sgn;
      drive(0, 0, 1, sgn, "brk_alt16", (i < 16) ? V_FAST : v_settle(0));
    end
    settle_run(SL, "settle_a");

    // locked: start ignored, 7-run then flip keeps lock
    drive(0, 1, 0, 0, "locked_start", V_LOCK);
    drive(0, 0, 1, 0, "lk_seed", V_LOCK);
    for (int i = 0; i < 7; i++) drive(0, 0, 1, 1, "lk_run7", V_LOCK);
    drive(0, 0, 1, 0, "lk_flip", V_LOCK);

    // 8 consecutive ups with gaps -> relock in FAST
    for (int i = 1; i <= 8; i++) begin
      if (i % 3 == 0) drive(0, 0, 0, 0, "lk_gap", V_LOCK);
      drive(0, 0, 1, 1, "lk_run8", (i < 8) ? V_LOCK : V_FAST);
    end

    // nominal acquisition from relock
    acquire("nominal");
    settle_run(SL, "settle_b");
    drive(0, 1, 0, 0, "locked_stay", V_LOCK);

    // fresh LOCKED: seed + 8 same-sign ups, then reset mid-SETTLE
    for (int i = 0; i <= 8; i++) drive(0, 0, 1, 1, "lk_run_fresh", (i < 8) ? V_LOCK : V_FAST);
    acquire("reacq");
    settle_run(5, "settle_c");
    drive(1, 0, 0, 0, "rst_mid_settle", V_IDLE);
    drive(0, 0, 1, 0, "idle_final", V_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
